float_acc_sched: RTL and testbench

Sequencing controller that accumulates a streamed vector of floats into one sum using a single shared `float_adder` instance, which has a fixed 3-cycle latency and no handshake. The block feeds the N_MAC accumulation path. It hides the adder latency with three interleaved partial sums, one per pipeline phase. After the last element it reduces the partials to one result and returns it through a valid/ready output.

---
 rtl/float_acc_sched_pkg.sv | 16 +
 rtl/float_adder.sv | 95 +++++++++
 rtl/float_acc_sched.sv | 160 ++++++++++++++++
 tb/tb_float_acc_sched.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/float_acc_sched_pkg.sv
// Shared float format, adder latency and controller state encoding.
package float_acc_sched_pkg;
  localparam int E_BIT   = 8;
  localparam int F_BIT   = 23;
  localparam int WORD_W  = E_BIT + F_BIT + 1;
  localparam int ADD_LAT = 3;
  localparam int NSLOT   = 3;

  typedef enum logic [2:0] {
    ACCUM = 3'd0,
    DRAIN = 3'd1,
    RED_A = 3'd2,
    RED_B = 3'd3,
    DONE  = 3'd4
  } state_e;
endpackage

// File: rtl/float_adder.sv
// Three-stage IEEE-754 adder: align, add, normalise/round (RNE). Denormals flush to zero.
module float_adder #(
  parameter int EW = 8,
  parameter int FW = 23
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [EW+FW:0] a_i,
  input  logic [EW+FW:0] b_i,
  output logic [EW+FW:0] sum_o
);
  localparam int MW = FW + 1;
  localparam int XW = MW + 3;
  localparam int SW = $clog2(XW + 1);
  localparam logic [EW-1:0] EMAX = '1;

  function automatic logic [SW-1:0] lzc(input logic [XW-1:0] v);
    lzc = SW'(XW);
    for (int i = 0; i < XW; i++) if (v[i]) lzc = SW'(XW - 1 - i);
  endfunction

  logic [EW-1:0]   ea, eb, e_big, e_sml, ediff;
  logic [MW-1:0]   ma, mb, m_big, m_sml;
  logic [2*XW-1:0] sh;
  logic [XW-1:0]   sml_al;
  logic            a_big;

  always_comb begin
    ea     = a_i[EW+FW-1:FW];
    eb     = b_i[EW+FW-1:FW];
    ma     = (ea == '0) ? '0 : {1'b1, a_i[FW-1:0]};
    mb     = (eb == '0) ? '0 : {1'b1, b_i[FW-1:0]};
    a_big  = {ea, ma} >= {eb, mb};
    e_big  = a_big ? ea : eb;
    e_sml  = a_big ? eb : ea;
    m_big  = a_big ? ma : mb;
    m_sml  = a_big ? mb : ma;
    ediff  = e_big - e_sml;
    // shifted-out bits collapse into the sticky position
    sh     = {m_sml, 3'b000, {XW{1'b0}}} >> ((ediff > EW'(XW)) ? EW'(XW) : ediff);
    sml_al = {sh[2*XW-1:XW+1], sh[XW] | (|sh[XW-1:0])};
  end

  logic            s1_spec, s1_sign, s1_sub, s2_spec, s2_sign;
  logic [EW+FW:0]  s1_specv, s2_specv, res;
  logic [EW-1:0]   s1_exp, s2_exp;
  logic [XW-1:0]   s1_mb, s1_ms, nm;
  logic [XW:0]     s2_sum;
  logic [SW-1:0]   lz;
  logic [EW+1:0]   ex;
  logic [FW:0]     rm;
  logic            rnd;

  always_comb begin
    lz = lzc(s2_sum[XW-1:0]);
    if (s2_sum[XW]) begin
      nm = {s2_sum[XW:2], s2_sum[1] | s2_sum[0]};
      ex = (EW+2)'(s2_exp) + (EW+2)'(1);
    end else begin
      nm = s2_sum[XW-1:0] << lz;
      ex = (EW+2)'(s2_exp) - (EW+2)'(lz);
    end
    rnd = nm[2] & (nm[3] | nm[1] | nm[0]);
    rm  = {1'b0, nm[XW-2:3]} + (FW+1)'(rnd);
    ex  = ex + (EW+2)'(rm[FW]);
    if (s2_spec)                    res = s2_specv;
    else if (!nm[XW-1])             res = '0;
    else if (ex[EW+1] || ex == '0)  res = {s2_sign, {(EW+FW){1'b0}}};
    else if (ex >= (EW+2)'(EMAX))   res = {s2_sign, EMAX, {FW{1'b0}}};
    else                            res = {s2_sign, ex[EW-1:0], rm[FW-1:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_spec <= 1'b0; s1_specv <= '0; s1_sign <= 1'b0; s1_sub <= 1'b0;
      s1_exp  <= '0;   s1_mb    <= '0; s1_ms   <= '0;
      s2_spec <= 1'b0; s2_specv <= '0; s2_sign <= 1'b0; s2_exp <= '0; s2_sum <= '0;
      sum_o   <= '0;
    end else begin
      s1_spec  <= (ea == EMAX) || (eb == EMAX);
      s1_specv <= (ea == EMAX) ? a_i : b_i;
      s1_sign  <= a_big ? a_i[EW+FW] : b_i[EW+FW];
      s1_sub   <= a_i[EW+FW] ^ b_i[EW+FW];
      s1_exp   <= e_big;
      s1_mb    <= {m_big, 3'b000};
      s1_ms    <= sml_al;
      s2_spec  <= s1_spec;
      s2_specv <= s1_specv;
      s2_sign  <= s1_sign;
      s2_exp   <= s1_exp;
      s2_sum   <= s1_sub ? ({1'b0, s1_mb} - {1'b0, s1_ms}) : ({1'b0, s1_mb} + {1'b0, s1_ms});
      sum_o    <= res;
    end
  end
endmodule

// File: rtl/float_acc_sched.sv
// Streams a float vector into three phase-interleaved partial sums over one
// shared 3-cycle adder, then reduces the partials and offers the sum.
module float_acc_sched
  import float_acc_sched_pkg::*;
#(
  parameter int W   = WORD_W,
  parameter int LAT = ADD_LAT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy
);
  localparam int CW = $clog2(LAT);

  state_e                  state_q, state_d;
  logic [1:0]              ph_q, ph_d, k_q, k_d, k_eff, push_slot;
  logic [NSLOT-1:0][W-1:0] acc_q, acc_d, eff_val;
  logic [NSLOT-1:0]        occ_q, occ_d, eff_occ, wb_hit;
  logic [LAT-1:0]          trk_vld_q;
  logic [LAT-1:0][1:0]     trk_slot_q;
  logic [CW-1:0]           wait_q, wait_d;
  logic [W-1:0]            out_q, out_d, add_a, add_b, adder_out;
  logic                    push, wb_zero;

  float_adder #(.EW(E_BIT), .FW(F_BIT)) u_add (
    .clk(clk), .rst_n(rst_n), .a_i(add_a), .b_i(add_b), .sum_o(adder_out)
  );

  // Effective slot view: a writeback landing this cycle is forwarded.
  assign wb_zero = (adder_out[W-2:0] == '0);
  always_comb begin
    for (int i = 0; i < NSLOT; i++) begin
      wb_hit[i]  = trk_vld_q[LAT-1] && (trk_slot_q[LAT-1] == 2'(i));
      eff_occ[i] = wb_hit[i] ? !wb_zero : occ_q[i];
      eff_val[i] = wb_hit[i] ? adder_out : acc_q[i];
    end
  end
  assign k_eff = 2'(eff_occ[0]) + 2'(eff_occ[1]) + 2'(eff_occ[2]);

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    acc_d     = acc_q;
    occ_d     = occ_q;
    k_d       = k_q;
    wait_d    = wait_q;
    out_d     = out_q;
    push      = 1'b0;
    push_slot = ph_q;
    add_a     = '0;
    add_b     = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (wb_hit[i]) begin
        acc_d[i] = adder_out;
        occ_d[i] = !wb_zero;
      end
    end
    case (state_q)
      ACCUM: begin
        ph_d = (ph_q == 2'd2) ? 2'd0 : ph_q + 2'd1;
        if (in_valid) begin
          if (in_data[W-2:0] != '0) begin
            if (!eff_occ[ph_q]) begin
              acc_d[ph_q] = in_data;
              occ_d[ph_q] = 1'b1;
            end else begin
              add_a       = in_data;
              add_b       = eff_val[ph_q];
              push        = 1'b1;
              occ_d[ph_q] = 1'b0;
            end
          end
          if (in_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Decide as soon as only the tail is in flight; its result is forwarded.
        if (trk_vld_q[LAT-2:0] == '0) begin
          k_d    = k_eff;
          wait_d = CW'(LAT - 1);
          case (k_eff)
            2'd0: begin out_d = '0; state_d = DONE; end
            2'd1: begin
              out_d   = eff_occ[0] ? eff_val[0] : (eff_occ[1] ? eff_val[1] : eff_val[2]);
              state_d = DONE;
            end
            default: begin
              add_a   = eff_occ[0] ? eff_val[0] : eff_val[1];
              add_b   = (eff_occ[0] && eff_occ[1]) ? eff_val[1] : eff_val[2];
              state_d = RED_A;
            end
          endcase
        end
      end
      RED_A: begin
        if (wait_q != '0) wait_d = wait_q - 1'b1;
        else if (k_q == 2'd2) begin
          out_d   = adder_out;
          state_d = DONE;
        end else begin
          add_a   = adder_out;
          add_b   = acc_q[2];
          wait_d  = CW'(LAT - 1);
          state_d = RED_B;
        end
      end
      RED_B: begin
        if (wait_q != '0) wait_d = wait_q - 1'b1;
        else begin
          out_d   = adder_out;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          acc_d   = '0;
          occ_d   = '0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      ph_q       <= '0;
      acc_q      <= '0;
      occ_q      <= '0;
      trk_vld_q  <= '0;
      trk_slot_q <= '0;
      k_q        <= '0;
      wait_q     <= '0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      acc_q      <= acc_d;
      occ_q      <= occ_d;
      trk_vld_q  <= {trk_vld_q[LAT-2:0], push};
      trk_slot_q <= {trk_slot_q[LAT-2:0], push_slot};
      k_q        <= k_d;
      wait_q     <= wait_d;
      out_q      <= out_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_q;
  assign busy      = !((state_q == ACCUM) && (occ_q == '0) && (trk_vld_q == '0));
endmodule

// File: tb/tb_float_acc_sched.sv
// Vector-sum bench: directed cases plus random vectors of half-integer floats
// whose exact sum is computed with integer arithmetic.
module tb_float_acc_sched;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, busy;
  logic [31:0] in_data = '0, out_data;
  int          n_chk = 0, n_fail = 0;
  int          vq[$], iq[$];

  float_acc_sched dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // value given in units of 0.5
  function automatic logic [31:0] h2f(input int h);
    int m, e;
    logic [31:0] r;
    if (h == 0) return 32'h0;
    m = (h < 0) ? -h : h;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    r[31]    = (h < 0);
    r[30:23] = 8'(126 + e);
    r[22:0]  = 23'((m << (23 - e)) & 32'h7FFFFF);
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic add(input int h, input int idle);
    vq.push_back(h);
    iq.push_back(idle);
  endtask

  task automatic run_vec(input string tag, input logic [31:0] exp, input int hold, input int exp_lat);
    int rdy, lat;
    rdy = 0;
    foreach (vq[i]) begin
      repeat (iq[i]) @(negedge clk);
      in_valid = 1'b1;
      in_data  = h2f(vq[i]);
      in_last  = (i == vq.size() - 1);
      if (in_ready) rdy++;
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
    end
    check({tag, "/rdy"}, 64'(rdy), 64'(vq.size()));
    check({tag, "/drop"}, {63'd0, in_ready}, 64'd0);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "/valid"}, {63'd0, out_valid}, 64'd1);
    check({tag, "/data"}, {32'd0, out_data}, {32'd0, exp});
    if (exp_lat > 0) check({tag, "/lat"}, 64'(lat), 64'(exp_lat));
    repeat (hold) begin
      @(negedge clk);
      check({tag, "/hold"}, {30'd0, out_valid, in_ready, out_data}, {30'd0, 1'b1, 1'b0, exp});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "/ret"}, {62'd0, in_ready, out_valid}, 64'd2);
    vq.delete();
    iq.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, sum, h;
    repeat (3) @(negedge clk);
    check("reset", {29'd0, in_ready, out_valid, busy, out_data}, {29'd0, 1'b1, 1'b0, 1'b0, 32'h0});
    rst_n = 1'b1;

    add(3, 0);
    run_vec("single", 32'h3FC00000, 0, 2);

    add(2, 0); add(4, 0); add(6, 0); add(8, 0);
    run_vec("b2b", 32'h41200000, 0, 0);

    add(2, 0); add(-2, 2); add(4, 0);
    run_vec("cancel", 32'h40000000, 0, 0);

    add(2, 0); add(2, 1); add(2, 0); add(2, 1); add(2, 0); add(2, 0); add(2, 0);
    run_vec("gaps", 32'h40E00000, 5, 0);

    // reset while the two-slot reduction is in the adder
    in_valid = 1'b1; in_data = 32'h3F800000;
    @(negedge clk);
    in_data = 32'h40000000; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    @(negedge clk);
    check("red_a_busy", {62'd0, busy, in_ready}, 64'd2);
    rst_n = 1'b0;
    #1;
    check("rst_mid", {29'd0, in_ready, out_valid, busy, out_data}, {29'd0, 1'b1, 1'b0, 1'b0, 32'h0});
    @(negedge clk);
    rst_n = 1'b1;
    add(5, 0);
    run_vec("after_rst", 32'h40200000, 0, 2);

    // phase 0 right after reset: six elements leave three issues in flight, k=3
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 1; j <= 6; j++) add(2 * j, 0);
    run_vec("worst", 32'h41A80000, 0, 10);

    for (int n = 0; n < 40; n++) begin
      len = int'($urandom_range(1, 10));
      sum = 0;
      for (int j = 0; j < len; j++) begin
        h = int'($urandom_range(0, 32)) - 16;
        add(h, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        sum += h;
      end
      run_vec("rnd", h2f(sum), int'($urandom_range(0, 3)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
